// File: rtl/mux_arb_pkg.sv
// Shared encodings and limits for the N-input arbitrating mux.
package mux_arb_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int N_IN_MIN  = 2;
    localparam int N_IN_MAX  = 16;

    // Next index after idx, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/mux_arb_n_if.sv
// Producer/consumer handshake bundle for mux_arb_n.
interface mux_arb_n_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_IN       = 4
);
    localparam int SRC_W = $clog2(N_IN);

    logic [N_IN*DATA_WIDTH-1:0] in_data;
    logic [N_IN-1:0]            in_valid;
    logic [N_IN-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [SRC_W-1:0]           out_src;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/arb_grant_n.sv
// Combinational grant: fixed priority from 0, or first valid searching up from rr_ptr with wrap.
module arb_grant_n
    import mux_arb_pkg::*;
#(
    parameter  int N_IN    = 4,
    parameter  int RR_MODE = ARB_FIXED,
    localparam int SRC_W   = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  valid,
    input  logic [SRC_W-1:0] rr_ptr,
    output logic [N_IN-1:0]  grant,
    output logic [SRC_W-1:0] gnt_idx,
    output logic             gnt_any
);
    int idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = (RR_MODE == ARB_RR) ? int'(rr_ptr) + k : k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!gnt_any && valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = SRC_W'(idx);
                gnt_any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrating mux with a single registered output stage (not a skid buffer).
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_IN       = 4,
    parameter int RR_MODE    = ARB_FIXED
) (
    input  logic        clk,
    input  logic        rst,
    mux_arb_n_if.slave  bus
);
    localparam int SRC_W = $clog2(N_IN);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("mux_arb_n: N_IN out of range");
    end

    logic [N_IN-1:0]  grant;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [SRC_W-1:0] rr_ptr;
    logic             load_en;

    arb_grant_n #(.N_IN(N_IN), .RR_MODE(RR_MODE)) u_grant (
        .valid   (bus.in_valid),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load_en = ~bus.out_valid | bus.out_ready;
    // Held in reset so no producer believes a beat was taken while state is being cleared.
    assign bus.in_ready = grant & {N_IN{load_en & ~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= '0;
        end else if (load_en) begin
            if (gnt_any) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                bus.out_src   <= gnt_idx;
                rr_ptr        <= SRC_W'(wrap_inc(int'(gnt_idx), N_IN));
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: one fixed-priority and one round-robin instance, scoreboarded output beats.
module tb_mux_arb_n;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        logic [1:0] exp_src;
    } vec_t;

    logic  clk;
    logic  rst;
    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t q_f[$];
    beat_t q_r[$];
    vec_t  tbl[7];

    mux_arb_n_if #(.DATA_WIDTH(32), .N_IN(4)) bf ();
    mux_arb_n_if #(.DATA_WIDTH(32), .N_IN(4)) br ();

    mux_arb_n #(.DATA_WIDTH(32), .N_IN(4), .RR_MODE(ARB_FIXED)) dut_f (
        .clk (clk), .rst (rst), .bus (bf)
    );
    mux_arb_n #(.DATA_WIDTH(32), .N_IN(4), .RR_MODE(ARB_RR)) dut_r (
        .clk (clk), .rst (rst), .bus (br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A beat is consumed at the edge following a low phase with out_valid & out_ready.
    beat_t mon_f, mon_r;
    always @(negedge clk) begin
        if (bf.out_valid && bf.out_ready) begin
            if (q_f.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL fp_beat: unexpected src=%0d data=%h", bf.out_src, bf.out_data);
            end else begin
                mon_f = q_f.pop_front();
                chk("fp_beat", {bf.out_src, bf.out_data}, mon_f);
            end
        end
        if (br.out_valid && br.out_ready) begin
            if (q_r.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rr_beat: unexpected src=%0d data=%h", br.out_src, br.out_data);
            end else begin
                mon_r = q_r.pop_front();
                chk("rr_beat", {br.out_src, br.out_data}, mon_r);
            end
        end
    end

    initial begin
        tbl[0] = '{4'b0001, 4'b0001, 2'd0};
        tbl[1] = '{4'b1010, 4'b0010, 2'd1};
        tbl[2] = '{4'b1100, 4'b0100, 2'd2};
        tbl[3] = '{4'b1000, 4'b1000, 2'd3};
        tbl[4] = '{4'b0000, 4'b0000, 2'd0};
        tbl[5] = '{4'b1111, 4'b0001, 2'd0};
        tbl[6] = '{4'b0110, 4'b0010, 2'd1};

        // Reset with every channel requesting
        rst = 1'b1;
        bf.in_valid = '1; br.in_valid = '1;
        bf.out_ready = 1'b1; br.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bf.in_data[i*32 +: 32] = 32'hdead_0000 + i;
            br.in_data[i*32 +: 32] = 32'h0000_0100 + i;
        end
        #1;
        chk("rst_rdy_f0", bf.in_ready, 0);
        chk("rst_rdy_r0", br.in_ready, 0);
        repeat (2) begin
            tick();
            chk("rst_f", {bf.out_valid, bf.out_src, bf.out_data, bf.in_ready}, 0);
            chk("rst_r", {br.out_valid, br.out_src, br.out_data, br.in_ready}, 0);
        end
        bf.in_valid = '0; br.in_valid = '0;
        rst = 1'b0;
        tick();

        // Fixed-priority table
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 4; i++) bf.in_data[i*32 +: 32] = (r << 8) | i;
            bf.in_valid = tbl[r].vld;
            #1;
            chk($sformatf("tbl_rdy[%0d]", r), bf.in_ready, tbl[r].exp_rdy);
            if (tbl[r].exp_rdy != 0) q_f.push_back({tbl[r].exp_src, 32'((r << 8) | tbl[r].exp_src)});
            tick();
        end
        bf.in_valid = '0;
        tick(); tick();

        // ch1 beats ch3; ch3 follows once ch1 drops
        bf.in_data[1*32 +: 32] = 32'h11;
        bf.in_data[3*32 +: 32] = 32'h33;
        bf.in_valid = 4'b1010;
        #1 chk("fp_rdy_ch1", bf.in_ready, 4'b0010);
        q_f.push_back({2'd1, 32'h11});
        tick();
        bf.in_valid = 4'b1000;
        #1 chk("fp_rdy_ch3", bf.in_ready, 4'b1000);
        q_f.push_back({2'd3, 32'h33});
        tick();
        bf.in_valid = '0;
        tick(); tick();

        // Backpressure on the fixed instance
        bf.out_ready = 1'b0;
        bf.in_data[2*32 +: 32] = 32'h22;
        bf.in_valid = 4'b0100;
        #1 chk("bp_rdy_load", bf.in_ready, 4'b0100);
        q_f.push_back({2'd2, 32'h22});
        tick();
        bf.in_data[0 +: 32] = 32'h44;
        bf.in_valid = 4'b0001;
        repeat (3) begin
            #1;
            chk("bp_rdy_stall", bf.in_ready, 0);
            chk("bp_out_hold", {bf.out_valid, bf.out_src, bf.out_data}, {1'b1, 2'd2, 32'h22});
            tick();
        end
        bf.out_ready = 1'b1;
        #1 chk("bp_rdy_release", bf.in_ready, 4'b0001);
        q_f.push_back({2'd0, 32'h44});
        tick();
        chk("bp_same_edge", {bf.out_valid, bf.out_src, bf.out_data}, {1'b1, 2'd0, 32'h44});
        bf.in_valid = '0;
        tick(); tick();

        // Round-robin, all channels valid
        br.in_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("rr_rdy[%0d]", c), br.in_ready, 4'b0001 << (c % 4));
            q_r.push_back({2'(c % 4), 32'h100 + 32'(c % 4)});
            tick();
        end
        br.in_valid = '0;
        tick();

        // Drive rr_ptr to 3, then wrap through a stall
        br.in_data[2*32 +: 32] = 32'h202;
        br.in_valid = 4'b0100;
        #1 chk("rr_rdy_ch2", br.in_ready, 4'b0100);
        q_r.push_back({2'd2, 32'h202});
        tick();
        br.in_data[3*32 +: 32] = 32'h303;
        br.in_data[0 +: 32]    = 32'h300;
        br.in_valid = 4'b1001;
        #1 chk("rr_wrap_ch3", br.in_ready, 4'b1000);
        q_r.push_back({2'd3, 32'h303});
        tick();
        br.out_ready = 1'b0;
        br.in_data[1*32 +: 32] = 32'h301;
        br.in_valid = 4'b0011;
        repeat (3) begin
            #1;
            chk("rr_rdy_stall", br.in_ready, 0);
            chk("rr_out_hold", {br.out_valid, br.out_src, br.out_data}, {1'b1, 2'd3, 32'h303});
            tick();
        end
        br.out_ready = 1'b1;
        #1 chk("rr_wrap_ch0", br.in_ready, 4'b0001);
        q_r.push_back({2'd0, 32'h300});
        tick();
        chk("rr_same_edge", {br.out_valid, br.out_src, br.out_data}, {1'b1, 2'd0, 32'h300});
        br.in_valid = 4'b0010;
        #1 chk("rr_after_wrap", br.in_ready, 4'b0010);
        q_r.push_back({2'd1, 32'h301});
        tick();
        br.in_valid = '0;
        tick(); tick();

        // Reset while a stalled beat is held: it must never reach the consumer
        bf.out_ready = 1'b0;
        bf.in_data[1*32 +: 32] = 32'h55;
        bf.in_valid = 4'b0010;
        #1 chk("mid_rst_rdy", bf.in_ready, 4'b0010);
        tick();
        bf.in_valid = '0;
        chk("mid_rst_held", {bf.out_valid, bf.out_src, bf.out_data}, {1'b1, 2'd1, 32'h55});
        rst = 1'b1;
        tick();
        chk("mid_rst_clear", {bf.out_valid, bf.out_src, bf.out_data}, 0);
        rst = 1'b0;
        bf.out_ready = 1'b1;
        repeat (3) tick();

        chk("q_f_empty", q_f.size(), 0);
        chk("q_r_empty", q_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
